// File: rtl/clk_period_meter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_period_meter_pkg: state encoding and clock-rate constant shared with the NCO.
// Rev 1.0
// ----------------------------------------------------------------------------
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Window counter needs at least one bit even when no averaging is done.
  function automatic int unsigned win_width(input int unsigned avg_log2);
    return (avg_log2 == 0) ? 1 : avg_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_edge_det: 2-flop synchronizer plus single-cycle rising-edge pulse.
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_period_meter: measures the period of sig_in in clk cycles, averaged over
// 2^AVG_LOG2 back-to-back periods, with single-shot or continuous operation.
// Rev 1.0
// ----------------------------------------------------------------------------
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AVG_LOG2 = 0,
  parameter int unsigned TIMEOUT  = 100000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [WIDTH-1:0] num,
  output logic             num_valid,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned       ACC_W    = WIDTH + AVG_LOG2;
  localparam int unsigned       WIN_W    = win_width(AVG_LOG2);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0]  CNT_MAX  = WIDTH'(TIMEOUT);

  generate
    if (AVG_LOG2 > 4) begin : g_bad_avg
      $error("clk_period_meter: AVG_LOG2 must be in 0..4");
    end
    if ((WIDTH < 32) && (64'(TIMEOUT) >= (64'd1 << WIDTH))) begin : g_bad_timeout
      $error("clk_period_meter: TIMEOUT must be below 2^WIDTH");
    end
  endgenerate

  logic rise;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sig_in),
    .rise     (rise)
  );

  state_e           state_q, state_d;
  logic             cont_q, cont_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             num_valid_q, num_valid_d;
  logic             timeout_q, timeout_d;
  logic [ACC_W-1:0] sum;

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    win_d       = win_q;
    num_d       = num_q;
    num_valid_d = 1'b0;
    timeout_d   = 1'b0;
    // Running total including the period that ends on this cycle's edge.
    sum         = acc_q + ACC_W'(cnt_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cont_d  = cont;
          cnt_d   = '0;
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        if (rise) begin
          cnt_d   = WIDTH'(1);
          acc_d   = '0;
          win_d   = '0;
          state_d = ST_MEASURE;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end

      ST_MEASURE: begin
        // A rise coinciding with cnt==TIMEOUT is a valid period, not a timeout.
        if (rise) begin
          cnt_d = WIDTH'(1);
          if (win_q == WIN_LAST) begin
            num_d       = WIDTH'(sum >> AVG_LOG2);
            num_valid_d = 1'b1;
            acc_d       = '0;
            win_d       = '0;
            if (!cont_q) begin
              state_d = ST_IDLE;
            end
          end else begin
            acc_d = sum;
            win_d = win_q + WIN_W'(1);
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cont_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      win_q       <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      win_q       <= win_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_clk_period_meter: two meters (AVG_LOG2=0 and 2) share one sig_in; expected
// results are derived from the generated period list and scored on output.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_clk_period_meter;

  localparam int unsigned TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [31:0] num0, num1;
  logic        nv0, nv1, to0, to1, busy0, busy1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_to;
    logic [31:0] val;
    bit          bsy;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] hold0 = 32'd0;
  logic [31:0] hold1 = 32'd0;
  int          per_q[$];

  clk_period_meter #(.WIDTH(32), .AVG_LOG2(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .num(num0), .num_valid(nv0), .timeout(to0), .busy(busy0)
  );

  clk_period_meter #(.WIDTH(32), .AVG_LOG2(2), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .num(num1), .num_valid(nv1), .timeout(to1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Reference: each window's result is the truncated mean of the next 2^avg
  // periods; running out of edges or a period above TMO ends in a timeout.
  task automatic predict(input int d, input bit c, input int s_cyc);
    int     n;
    int     sh;
    int     i;
    longint sum;
    sh = (d == 0) ? 0 : 2;
    n  = 1 << sh;
    i  = 0;
    if (per_q.size() == 0) begin
      push(d, '{1'b1, 32'd0, 1'b0, s_cyc + int'(TMO) + 2});
      return;
    end
    forever begin
      sum = 0;
      for (int j = 0; j < n; j++) begin
        if (i >= per_q.size() || per_q[i] > int'(TMO)) begin
          push(d, '{1'b1, 32'd0, 1'b0, -1});
          return;
        end
        sum += longint'(per_q[i]);
        i++;
      end
      push(d, '{1'b0, 32'(sum >> sh), c, -1});
      if (!c) return;
    end
  endtask

  task automatic check_dut(input int d, input logic nv, input logic to,
                           input logic [31:0] num, input logic bsy);
    exp_t e;
    bit   empty;
    if (!(nv || to)) return;
    cmp($sformatf("dut%0d valid_timeout_exclusive", d), 32'(nv & to), 32'd0);
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d unexpected_output: num_valid=%0d timeout=%0d num=%0d, expected no output (cycle %0d)",
               d, nv, to, num, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    cmp($sformatf("dut%0d kind_is_timeout", d), 32'(to), 32'(e.is_to));
    if (e.is_to) begin
      cmp($sformatf("dut%0d num_held", d), num, (d == 0) ? hold0 : hold1);
    end else begin
      cmp($sformatf("dut%0d num", d), num, e.val);
      if (d == 0) hold0 = e.val;
      else        hold1 = e.val;
    end
    cmp($sformatf("dut%0d busy_at_output", d), 32'(bsy), 32'(e.bsy));
    if (e.cyc >= 0) cmp($sformatf("dut%0d output_cycle", d), 32'(cyc), 32'(e.cyc));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_dut(0, nv0, to0, num0, busy0);
      check_dut(1, nv1, to1, num1, busy1);
    end
  end

  task automatic check_all_zero(input string tag);
    cmp({tag, " num0"}, num0, 32'd0);
    cmp({tag, " num1"}, num1, 32'd0);
    cmp({tag, " valid0"}, 32'(nv0), 32'd0);
    cmp({tag, " valid1"}, 32'(nv1), 32'd0);
    cmp({tag, " timeout0"}, 32'(to0), 32'd0);
    cmp({tag, " timeout1"}, 32'(to1), 32'd0);
    cmp({tag, " busy0"}, 32'(busy0), 32'd0);
    cmp({tag, " busy1"}, 32'(busy1), 32'd0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    q0.delete();
    q1.delete();
    hold0 = 32'd0;
    hold1 = 32'd0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q0.size() > 0 || q1.size() > 0) && w < 5000) begin
      tick();
      w++;
    end
    n_checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expected outputs still pending after %0d cycles, expected 0/0",
               q0.size(), q1.size(), w);
      q0.delete();
      q1.delete();
    end
    cmp("idle_busy0", 32'(busy0), 32'd0);
    cmp("idle_busy1", 32'(busy1), 32'd0);
    tick();
    tick();
  endtask

  // evt: 0 none, 1 extra start pulse, 2 async reset; applied at evt_off of period 0.
  task automatic run(input bit c, input int gap, input int evt, input int evt_off);
    int s_cyc;
    int p;
    int hi;
    sig_in = 1'b0;
    repeat (6) tick();
    start = 1'b1;
    cont  = c;
    s_cyc = cyc;
    predict(0, c, s_cyc);
    predict(1, c, s_cyc);
    tick();
    start = 1'b0;
    cont  = 1'($urandom_range(0, 1));
    repeat (gap) tick();
    for (int i = 0; i < per_q.size(); i++) begin
      p  = per_q[i];
      hi = (p / 2 < 1) ? 1 : p / 2;
      for (int k = 0; k < p; k++) begin
        sig_in = (k < hi);
        if (i == 0 && k == evt_off) begin
          if (evt == 1) begin
            start = 1'b1;
            cont  = ~c;
          end else if (evt == 2) begin
            do_reset();
          end
        end
        tick();
        start = 1'b0;
      end
    end
    if (per_q.size() > 0) begin
      sig_in = 1'b1;
      tick();
      sig_in = 1'b0;
    end
    drain();
  endtask

  initial begin
    repeat (3) tick();
    check_all_zero("reset_state");
    rst_n = 1'b1;
    repeat (3) tick();

    per_q = '{100, 100, 100, 100};
    run(1'b0, 5, 0, 0);
    per_q = '{10, 12, 10, 12};
    run(1'b0, 7, 0, 0);
    per_q = '{10, 10, 10, 11};
    run(1'b0, 3, 0, 0);
    per_q.delete();
    run(1'b0, 0, 0, 0);
    per_q = '{1000, 1000, 1000, 1000};
    run(1'b0, 4, 0, 0);
    per_q = '{50, 50, 50, 50, 20, 20, 20, 20, 20};
    run(1'b1, 9, 0, 0);
    per_q = '{100, 90, 80, 70, 60};
    run(1'b0, 5, 1, 10);
    per_q = '{1001, 5, 5, 5, 5};
    run(1'b0, 2, 0, 0);

    for (int r = 0; r < 10; r++) begin
      int m;
      per_q.delete();
      m = $urandom_range(1, 10);
      for (int j = 0; j < m; j++) begin
        if ($urandom_range(0, 9) == 0) per_q.push_back($urandom_range(995, 1000));
        else                           per_q.push_back($urandom_range(2, 60));
      end
      run(1'($urandom_range(0, 1)), $urandom_range(1, 30), 0, 0);
    end

    per_q = '{200, 200, 200, 200, 200, 200};
    run(1'b0, 5, 2, 50);
    cmp("post_reset_num0", num0, 32'd0);
    cmp("post_reset_num1", num1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures the period of an incoming square wave, e.g. the output of the team's numerically controlled oscillator or an external clock pin, in units of the 50 MHz system clk.
- Reports the period as a 32-bit cycle count in the same form as the oscillator's divide input, so the measured value can be fed straight back to regenerate the same frequency.
- Used for closed-loop checks and for frequency display on the board.

Parameters:
WIDTH, 32, width of the period result and counter
AVG_LOG2, 0, result is the mean of 2^AVG_LOG2 consecutive periods (0..4)
TIMEOUT, 100000000, maximum measurable period in clk cycles; longer periods cause a timeout

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
sig_in  in  1  signal to measure; asynchronous to clk
start  in  1  single-cycle pulse; begins a measurement; ignored while busy
cont  in  1  continuous mode; sampled when start is accepted
num  out  WIDTH  measured period in clk cycles (averaged), held until next update
num_valid  out  1  one-cycle pulse when num is updated
timeout  out  1  one-cycle pulse when no edge arrives within TIMEOUT cycles
busy  out  1  high in ARM or MEASURE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; num=0, num_valid=0, timeout=0, busy=0; synchronizer, edge register, cnt, accumulator and window counter all cleared. Reset mid-measurement discards all partial results.
- Input path: 2-flop synchronizer plus one history flop. An edge (rise) is high for one cycle when synced=1 and prev=0.
  - Fixed 2-3 cycle detection delay; it cancels out in period differences.
  - Minimum measurable period is 2 cycles.
- States:
  - IDLE:
    - busy=0.
    - start=1: latch cont into cont_r, cnt<=0, go to ARM.
  - ARM, waiting for the first edge:
    - cnt increments each cycle.
    - On rise: cnt<=1, acc<=0, win<=0, go to MEASURE.
  - MEASURE:
    - No rise: cnt<=cnt+1.
    - On rise: acc<=acc+cnt, win<=win+1, cnt<=1.
    - Period definition: edges detected at cycles t0 and t1 give period = t1-t0.
    - Window completion: when a rise occurs with win==2^AVG_LOG2-1, num<=(acc+cnt)>>AVG_LOG2 (truncating) and num_valid=1 in the next cycle.
      - cont_r=1: acc<=0, win<=0, stay in MEASURE. The completing edge is the start of the next window, so there are no gaps between windows.
      - cont_r=0: go to IDLE.
- Timeout:
  - In ARM or MEASURE, if cnt==TIMEOUT and no rise occurs this cycle, timeout=1 for the next cycle, go to IDLE, and leave num unchanged.
  - Applies in continuous mode too; the host must re-issue start.
- Widths:
  - acc is WIDTH+AVG_LOG2 bits, so it cannot overflow.
  - cnt is WIDTH bits; it never exceeds TIMEOUT, which must be < 2^WIDTH.
- start while busy: ignored, including in continuous mode.
- Stopping continuous mode requires rst_n; no abort input exists.
- Simultaneous rise and cnt==TIMEOUT: the rise wins, the period is TIMEOUT, and no timeout is raised.
- num_valid and timeout are never high together.

Decomposition:
- Shared package: state encoding constants (IDLE, ARM, MEASURE) and the default clock-rate constant (50_000_000), shared with the oscillator.
- One natural sub-module, sync_edge_det: 2-flop synchronizer plus rising-edge pulse, reusable for buttons and other async inputs.
- Counter, accumulator and FSM stay in the top module.

Test Plan:
- NCO with num=100 driving sig_in, start, cont=0, AVG_LOG2=0 -> one num_valid pulse with num=100; busy falls in the same cycle num_valid rises.
- AVG_LOG2=2, sig_in periods 10,12,10,12 cycles -> a single num_valid with num=11; periods 10,10,10,11 -> num=10 (truncation).
- cont=1, NCO num=50000 then changed to 20000 -> num_valid every 50000 cycles with num=50000, then num=20000 after at most one transitional value; no timeout.
- TIMEOUT=1000, sig_in held low, start at cycle S -> timeout pulse at cycle S+1002, busy=0 afterwards, num keeps its previous value. Then periods of exactly 1000 measure as num=1000 with no timeout.
- Second start pulse during MEASURE -> ignored, measurement result unchanged. rst_n asserted mid-MEASURE -> all outputs 0 immediately (async); after release, no num_valid until a new start.
